// File: rtl/boot_sequencer.sv
// Bootload controller: parses a framed byte stream and writes program images
// into the CPU's instruction and data memories.
module boot_sequencer #(
  parameter int          BITS  = 32,
  parameter int          ADDRW = 13,
  parameter logic [7:0]  MAGIC = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [BITS-1:0]  wdata_data,
  output logic [ADDRW:0]   wdata_addr,
  output logic [2:0]       dst,
  output logic             bootloading,
  output logic             boot_done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_CNT_LO = 3'd2,
    S_CNT_HI = 3'd3,
    S_DATA   = 3'd4,
    S_RUN    = 3'd5
  } state_e;

  // Largest word count a single section may carry.
  localparam logic [16:0] CNT_MAX = 17'd1 << ADDRW;

  state_e            state_q, state_d;
  logic              tgt_imem_q, tgt_imem_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [ADDRW:0]    cnt_q, cnt_d;
  logic [ADDRW:0]    word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       asm_q, asm_d;
  logic [BITS-1:0]   wdata_data_q, wdata_data_d;
  logic [ADDRW:0]    wdata_addr_q, wdata_addr_d;
  logic [2:0]        dst_q, dst_d;
  logic              bootloading_q, bootloading_d;
  logic              boot_done_q, boot_done_d;
  logic              err_q, err_d;

  logic [15:0]       cnt_full_s;
  logic [31:0]       word_s;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tgt_imem_q    <= 1'b0;
      cnt_lo_q      <= 8'd0;
      cnt_q         <= '0;
      word_idx_q    <= '0;
      byte_idx_q    <= 2'd0;
      asm_q         <= 32'd0;
      wdata_data_q  <= '0;
      wdata_addr_q  <= '0;
      dst_q         <= 3'b000;
      bootloading_q <= 1'b1;
      boot_done_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_imem_q    <= tgt_imem_d;
      cnt_lo_q      <= cnt_lo_d;
      cnt_q         <= cnt_d;
      word_idx_q    <= word_idx_d;
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      wdata_data_q  <= wdata_data_d;
      wdata_addr_q  <= wdata_addr_d;
      dst_q         <= dst_d;
      bootloading_q <= bootloading_d;
      boot_done_q   <= boot_done_d;
      err_q         <= err_d;
    end
  end

  // Frame parser: next state, byte assembly and write strobe generation.
  always_comb begin
    state_d       = state_q;
    tgt_imem_d    = tgt_imem_q;
    cnt_lo_d      = cnt_lo_q;
    cnt_d         = cnt_q;
    word_idx_d    = word_idx_q;
    byte_idx_d    = byte_idx_q;
    asm_d         = asm_q;
    wdata_data_d  = wdata_data_q;
    wdata_addr_d  = wdata_addr_q;
    dst_d         = 3'b000;
    bootloading_d = bootloading_q;
    boot_done_d   = 1'b0;
    err_d         = err_q;
    cnt_full_s    = {rx_data, cnt_lo_q};
    word_s        = asm_q;
    word_s[byte_idx_q*8 +: 8] = rx_data;

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == MAGIC) begin
            state_d = S_CMD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          case (rx_data)
            8'h01: begin
              tgt_imem_d = 1'b1;
              state_d    = S_CNT_LO;
            end
            8'h02: begin
              tgt_imem_d = 1'b0;
              state_d    = S_CNT_LO;
            end
            8'h03: begin
              bootloading_d = 1'b0;
              boot_done_d   = 1'b1;
              state_d       = S_RUN;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_CNT_LO: begin
          cnt_lo_d = rx_data;
          state_d  = S_CNT_HI;
        end
        S_CNT_HI: begin
          // The range check guarantees word addresses never wrap.
          if (cnt_full_s == 16'd0) begin
            state_d = S_IDLE;
          end else if ({1'b0, cnt_full_s} > CNT_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d      = cnt_full_s[ADDRW:0];
            word_idx_d = '0;
            byte_idx_d = 2'd0;
            state_d    = S_DATA;
          end
        end
        S_DATA: begin
          asm_d      = word_s;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wdata_data_d = BITS'(word_s);
            wdata_addr_d = {1'b0, word_idx_q[ADDRW-1:0]};
            dst_d        = tgt_imem_q ? 3'b100 : 3'b010;
            word_idx_d   = word_idx_q + 1'b1;
            if ((word_idx_q + 1'b1) == cnt_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign wdata_data  = wdata_data_q;
  assign wdata_addr  = wdata_addr_q;
  assign dst         = dst_q;
  assign bootloading = bootloading_q;
  assign boot_done   = boot_done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed, table-driven bench for boot_sequencer: per-cycle stimulus records
// carry the hand-computed outputs expected just after each clock edge.
module tb_boot_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] wdata_data;
  logic [13:0] wdata_addr;
  logic [2:0]  dst;
  logic        bootloading;
  logic        boot_done;
  logic        err;

  boot_sequencer #(.BITS(32), .ADDRW(13), .MAGIC(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wdata_data(wdata_data), .wdata_addr(wdata_addr), .dst(dst),
    .bootloading(bootloading), .boot_done(boot_done), .err(err)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  b;
    logic [2:0]  dst;
    logic [13:0] addr;
    logic [31:0] data;
    logic        boot;
    logic        done;
    logic        err;
  } vec_t;

  vec_t        tbl[$];
  int          total = 0;
  int          bad = 0;
  logic [13:0] e_addr;
  logic [31:0] e_data;
  logic        e_boot, e_done, e_err;

  always #5 clk = ~clk;

  task automatic put(input logic r, input logic v, input logic [7:0] b, input logic [2:0] d);
    vec_t x;
    x.rst = r; x.vld = v; x.b = b; x.dst = d;
    x.addr = e_addr; x.data = e_data; x.boot = e_boot; x.done = e_done; x.err = e_err;
    tbl.push_back(x);
  endtask

  task automatic bytes(input logic [7:0] s[]);
    foreach (s[k]) put(1'b0, 1'b1, s[k], 3'b000);
  endtask

  task automatic check(input string name, input logic [2:0] xd, input logic [13:0] xa,
                       input logic [31:0] xw, input logic xb, input logic xn, input logic xe);
    total++;
    if ({dst, wdata_addr, wdata_data, bootloading, boot_done, err} !== {xd, xa, xw, xb, xn, xe}) begin
      bad++;
      $display("FAIL %s: got dst=%b addr=%h data=%h boot=%b done=%b err=%b, want dst=%b addr=%h data=%h boot=%b done=%b err=%b",
               name, dst, wdata_addr, wdata_data, bootloading, boot_done, err, xd, xa, xw, xb, xn, xe);
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; rx_valid = tbl[i].vld; rx_data = tbl[i].b;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, i), tbl[i].dst, tbl[i].addr, tbl[i].data,
            tbl[i].boot, tbl[i].done, tbl[i].err);
    end
    tbl.delete();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    e_addr = 14'd0; e_data = 32'd0; e_boot = 1'b1; e_done = 1'b0; e_err = 1'b0;

    // Reset values.
    put(1'b1, 1'b0, 8'h00, 3'b000);
    put(1'b1, 1'b0, 8'h00, 3'b000);
    // Two-word IMEM load; 6F lands in the strobe cycle of the first word.
    bytes('{8'hA5, 8'h01, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00});
    e_addr = 14'd0; e_data = 32'h00000013;
    put(1'b0, 1'b1, 8'h00, 3'b100);
    bytes('{8'h6F, 8'h00, 8'h00});
    e_addr = 14'd1; e_data = 32'h0000006F;
    put(1'b0, 1'b1, 8'h00, 3'b100);
    put(1'b0, 1'b0, 8'h00, 3'b000);
    // Back-to-back DMEM word.
    bytes('{8'hA5, 8'h02, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD});
    e_addr = 14'd0; e_data = 32'hDEADBEEF;
    put(1'b0, 1'b1, 8'hDE, 3'b010);
    put(1'b0, 1'b0, 8'h00, 3'b000);
    // Garbage then count zero: nothing happens.
    bytes('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h00});
    put(1'b0, 1'b0, 8'h00, 3'b000);
    // Gapped rx_valid within a word; also proves parser returned to IDLE.
    bytes('{8'hA5, 8'h02, 8'h01, 8'h00, 8'h01});
    put(1'b0, 1'b0, 8'h77, 3'b000);
    bytes('{8'h02});
    put(1'b0, 1'b0, 8'h88, 3'b000);
    bytes('{8'h03});
    e_data = 32'h04030201;
    put(1'b0, 1'b1, 8'h04, 3'b010);
    // Bad command, then oversize count.
    bytes('{8'hA5});
    e_err = 1'b1;
    bytes('{8'h07, 8'hA5, 8'h01, 8'hFF, 8'hFF});
    // A valid frame still loads after errors.
    bytes('{8'hA5, 8'h01, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34});
    e_data = 32'h12345678;
    put(1'b0, 1'b1, 8'h12, 3'b100);
    // MAGIC inside DATA is payload.
    bytes('{8'hA5, 8'h01, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5});
    e_data = 32'hA5A5A5A5;
    put(1'b0, 1'b1, 8'hA5, 3'b100);
    put(1'b0, 1'b0, 8'h00, 3'b000);
    // Partial frame that the reset below interrupts.
    bytes('{8'hA5, 8'h01, 8'h01, 8'h00, 8'h11, 8'h22});
    run_table("a");

    // Asynchronous reset mid-word: outputs must clear before any clock edge.
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_rst", 3'b000, 14'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("rst_hold", 3'b000, 14'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    e_addr = 14'd0; e_data = 32'd0; e_boot = 1'b1; e_done = 1'b0; e_err = 1'b0;
    put(1'b0, 1'b0, 8'h00, 3'b000);
    bytes('{8'hA5, 8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33});
    e_data = 32'h44332211;
    put(1'b0, 1'b1, 8'h44, 3'b100);
    // Count 8193 is one past the limit.
    bytes('{8'hA5, 8'h01, 8'h01});
    e_err = 1'b1;
    bytes('{8'h20});
    // RUN releases the CPU; later frames are ignored.
    bytes('{8'hA5});
    e_boot = 1'b0; e_done = 1'b1;
    bytes('{8'h03});
    e_done = 1'b0;
    bytes('{8'hA5, 8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h03});
    put(1'b0, 1'b0, 8'h00, 3'b000);
    run_table("b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
